intg_frame_feeder: RTL and testbench



---
 rtl/intg_pkg.sv | 28 ++
 rtl/intg_frame_feeder_if.sv | 24 ++
 rtl/intg_row_unpack.sv | 19 +
 rtl/intg_frame_feeder.sv | 178 +++++++++++++++++
 tb/tb_intg_frame_feeder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intg_pkg.sv
// Shared types and helpers for the integral-stream frame feeder.
package intg_pkg;

  // Default component width used by system-level users of lane_t.
  localparam int LANE_W = 32;

  // Four complex lanes, one component (real or imaginary) per array.
  typedef logic [3:0][LANE_W-1:0] lane_t;

  // Feeder sequencing: wait for start, issue reads, flush the read pipeline.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } intg_state_e;

  // Bit offset of lane k's real part inside a row word of w-bit components.
  // Lane k occupies [k*2w +: 2w]; real sits in the upper half.
  function automatic int lane_re_lsb(input int k, input int w);
    return k * 2 * w + w;
  endfunction

  // Bit offset of lane k's imaginary part (lower half of the lane).
  function automatic int lane_im_lsb(input int k, input int w);
    return k * 2 * w;
  endfunction

endpackage

// File: rtl/intg_frame_feeder_if.sv
// Four-lane col1/col2 stream toward the integral block.
// Handshake: valid-only. A beat is transferred on every clock edge where
// valid is high; there is no ready and the sink must accept every beat.
// When valid is low, all lane data and both indices are zero.
interface intg_frame_feeder_if #(
  parameter int W      = 32,
  parameter int ADDR_W = 11
);
  logic                 valid;
  logic [3:0][W-1:0]    col1_r;
  logic [3:0][W-1:0]    col1_i;
  logic [3:0][W-1:0]    col2_r;
  logic [3:0][W-1:0]    col2_i;
  logic [ADDR_W-1:0]    index_col_1;
  logic [ADDR_W-1:0]    index_col_2;

  modport master (
    output valid, col1_r, col1_i, col2_r, col2_i, index_col_1, index_col_2
  );

  modport slave (
    input valid, col1_r, col1_i, col2_r, col2_i, index_col_1, index_col_2
  );
endinterface

// File: rtl/intg_row_unpack.sv
// Splits one 8W-bit row word into real and imaginary lane arrays.
module intg_row_unpack
  import intg_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [8*W-1:0]  row,
  output logic [3:0][W-1:0] re,
  output logic [3:0][W-1:0] im
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam int RE_LSB = lane_re_lsb(k, W);
    localparam int IM_LSB = lane_im_lsb(k, W);
    assign re[k] = row[RE_LSB +: W];
    assign im[k] = row[IM_LSB +: W];
  end

endmodule

// File: rtl/intg_frame_feeder.sv
// Reads one rfft frame from a synchronous-read bin buffer and replays it on
// the col1/col2 stream in the beat/index order the integral block expects.
// Pipeline: read address register -> buffer -> output register (2 edges).
module intg_frame_feeder
  import intg_pkg::*;
#(
  parameter  int IN_DATA_WIDTH = 32,
  parameter  int ROWS          = 2048,
  localparam int ADDR_W        = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en_a,
  output logic [ADDR_W-1:0]          rd_addr_a,
  input  logic [8*IN_DATA_WIDTH-1:0] rd_data_a,
  output logic                       rd_en_b,
  output logic [ADDR_W-1:0]          rd_addr_b,
  input  logic [8*IN_DATA_WIDTH-1:0] rd_data_b,
  intg_frame_feeder_if.master        strm,
  output intg_state_e                state_dbg
);

  localparam int                HALF      = ROWS / 2;
  // Beats run 0..ROWS/2, so ROWS/2 is the final beat; it fits in ADDR_W bits.
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(HALF);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

  intg_state_e       state_q, state_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic              drain_q, drain_d;
  logic              issue, finish;

  logic [ADDR_W-1:0] pair_base;
  logic              col2_act;
  logic [ADDR_W-1:0] addr_a_d, addr_b_d;

  // Stage 2 tags travel alongside the buffer's read latency.
  logic              s2_v, s2_c2;
  logic [ADDR_W-1:0] s2_idx1, s2_idx2;

  logic [3:0][IN_DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;

  logic                          valid_q;
  logic [3:0][IN_DATA_WIDTH-1:0] col1_r_q, col1_i_q, col2_r_q, col2_i_q;
  logic [ADDR_W-1:0]             idx1_q, idx2_q;

  // FSM state, current beat number and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // Next state; 'issue' means a read pair for beat_d goes out at this edge.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    issue   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          beat_d  = '0;
          issue   = 1'b1;
        end
      end
      RUN: begin
        if (beat_q == LAST_BEAT) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          beat_d = beat_q + ONE;
          issue  = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row addresses for beat_d: beats 0/1 carry rows 0/1 on col1 only,
  // later beats carry the pair (2(k-1), 2(k-1)+1).
  always_comb begin
    pair_base = (beat_d - ONE) << 1;
    col2_act  = (beat_d >= TWO);
    addr_a_d  = col2_act ? pair_base : beat_d;
    addr_b_d  = col2_act ? (pair_base | ONE) : '0;
  end

  // Read-request register, stage-2 tags and busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_a   <= 1'b0;
      rd_addr_a <= '0;
      rd_en_b   <= 1'b0;
      rd_addr_b <= '0;
      s2_v      <= 1'b0;
      s2_c2     <= 1'b0;
      s2_idx1   <= '0;
      s2_idx2   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en_a   <= issue;
      rd_addr_a <= issue ? addr_a_d : '0;
      rd_en_b   <= issue & col2_act;
      rd_addr_b <= (issue & col2_act) ? addr_b_d : '0;
      s2_v      <= rd_en_a;
      s2_c2     <= rd_en_b;
      s2_idx1   <= rd_addr_a;
      s2_idx2   <= rd_addr_b;
      busy      <= (busy | (state_q == IDLE && start)) & ~finish;
      done      <= finish;
    end
  end

  intg_row_unpack #(.W(IN_DATA_WIDTH)) u_unpack_a (
    .row (rd_data_a),
    .re  (a_re),
    .im  (a_im)
  );

  intg_row_unpack #(.W(IN_DATA_WIDTH)) u_unpack_b (
    .row (rd_data_b),
    .re  (b_re),
    .im  (b_im)
  );

  // Output register; lanes are zeroed whenever their column is inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      col1_r_q <= '0;
      col1_i_q <= '0;
      col2_r_q <= '0;
      col2_i_q <= '0;
      idx1_q   <= '0;
      idx2_q   <= '0;
    end else begin
      valid_q  <= s2_v;
      col1_r_q <= s2_v  ? a_re : '0;
      col1_i_q <= s2_v  ? a_im : '0;
      col2_r_q <= s2_c2 ? b_re : '0;
      col2_i_q <= s2_c2 ? b_im : '0;
      idx1_q   <= s2_v  ? s2_idx1 : '0;
      idx2_q   <= s2_c2 ? s2_idx2 : '0;
    end
  end

  assign strm.valid       = valid_q;
  assign strm.col1_r      = col1_r_q;
  assign strm.col1_i      = col1_i_q;
  assign strm.col2_r      = col2_r_q;
  assign strm.col2_i      = col2_i_q;
  assign strm.index_col_1 = idx1_q;
  assign strm.index_col_2 = idx2_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_intg_frame_feeder.sv
// Bench for intg_frame_feeder: a 2048-row and a 16-row instance, each fed by
// a synchronous-read buffer model, checked every cycle against a frame-level
// model plus hand-computed literal expectations.
module tb_intg_frame_feeder;
  import intg_pkg::*;

  localparam int W     = 32;
  localparam int ROWS  = 2048;
  localparam int AW    = 11;
  localparam int ROWS2 = 16;
  localparam int AW2   = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic start, start16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT: 2048 rows ----------------
  logic              busy, done, rd_en_a, rd_en_b;
  logic [AW-1:0]     rd_addr_a, rd_addr_b;
  logic [8*W-1:0]    rd_data_a, rd_data_b;
  intg_state_e       st_big;
  intg_frame_feeder_if #(.W(W), .ADDR_W(AW)) sif ();

  intg_frame_feeder #(.IN_DATA_WIDTH(W), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .strm(sif), .state_dbg(st_big)
  );

  // ---------------- DUT: 16 rows ----------------
  logic              busy16, done16, rd_en_a16, rd_en_b16;
  logic [AW2-1:0]    rd_addr_a16, rd_addr_b16;
  logic [8*W-1:0]    rd_data_a16, rd_data_b16;
  intg_state_e       st_16;
  intg_frame_feeder_if #(.W(W), .ADDR_W(AW2)) sif16 ();

  intg_frame_feeder #(.IN_DATA_WIDTH(W), .ROWS(ROWS2)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16),
    .rd_en_a(rd_en_a16), .rd_addr_a(rd_addr_a16), .rd_data_a(rd_data_a16),
    .rd_en_b(rd_en_b16), .rd_addr_b(rd_addr_b16), .rd_data_b(rd_data_b16),
    .strm(sif16), .state_dbg(st_16)
  );

  // ---------------- buffer model ----------------
  // Row r, lane k: real = 4r+k, imag = ~(4r+k). Disabled reads return garbage.
  function automatic logic [8*W-1:0] row_word(input int r);
    logic [8*W-1:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w[k*2*W+W +: W] = W'(4 * r + k);
      w[k*2*W   +: W] = ~W'(4 * r + k);
    end
    return w;
  endfunction

  function automatic logic [8*W-1:0] junk();
    logic [8*W-1:0] w;
    for (int k = 0; k < 8; k++) w[k*W +: W] = $urandom;
    return w;
  endfunction

  always @(posedge clk) begin
    rd_data_a   <= rd_en_a   ? row_word(int'(rd_addr_a))   : junk();
    rd_data_b   <= rd_en_b   ? row_word(int'(rd_addr_b))   : junk();
    rd_data_a16 <= rd_en_a16 ? row_word(int'(rd_addr_a16)) : junk();
    rd_data_b16 <= rd_en_b16 ? row_word(int'(rd_addr_b16)) : junk();
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit    busy, done, valid, en_a, en_b;
    int    st, addr_a, addr_b, idx1, idx2;
    lane_t c1r, c1i, c2r, c2i;
  } obs_t;

  // Row carried on col1 for beat k (col2 carries the next row when k >= 2).
  function automatic int col1_row(input int k);
    return (k < 2) ? k : 2 * (k - 1);
  endfunction

  // Frame-level model: offs = edges since the accepting edge.
  // Reads for beat k go out at offs=k, beat k is visible at offs=k+2,
  // done at offs=N+2 with N = ROWS/2+1 beats.
  function automatic obs_t model(input int rows, input bit fv, input longint offs);
    obs_t o;
    int   n, k, r;
    o = '{default: 0};
    o.st = int'(IDLE);
    n = rows / 2 + 1;
    if (!fv) return o;
    if (offs >= 0 && offs <= n + 1) o.busy = 1'b1;
    if (offs == n + 2) o.done = 1'b1;
    if (offs >= 0 && offs < n) begin
      k = int'(offs);
      o.st = int'(RUN);
      o.en_a = 1'b1;
      o.addr_a = col1_row(k);
      if (k >= 2) begin
        o.en_b = 1'b1;
        o.addr_b = col1_row(k) + 1;
      end
    end else if (offs == n || offs == n + 1) begin
      o.st = int'(DRAIN);
    end
    if (offs >= 2 && offs <= n + 1) begin
      k = int'(offs) - 2;
      r = col1_row(k);
      o.valid = 1'b1;
      o.idx1 = r;
      for (int l = 0; l < 4; l++) begin
        o.c1r[l] = W'(4 * r + l);
        o.c1i[l] = ~W'(4 * r + l);
      end
      if (k >= 2) begin
        o.idx2 = r + 1;
        for (int l = 0; l < 4; l++) begin
          o.c2r[l] = W'(4 * (r + 1) + l);
          o.c2i[l] = ~W'(4 * (r + 1) + l);
        end
      end
    end
    return o;
  endfunction

  function automatic obs_t observe_big();
    obs_t o;
    o.busy = busy; o.done = done; o.valid = sif.valid;
    o.en_a = rd_en_a; o.en_b = rd_en_b; o.st = int'(st_big);
    o.addr_a = int'(rd_addr_a); o.addr_b = int'(rd_addr_b);
    o.idx1 = int'(sif.index_col_1); o.idx2 = int'(sif.index_col_2);
    o.c1r = sif.col1_r; o.c1i = sif.col1_i; o.c2r = sif.col2_r; o.c2i = sif.col2_i;
    return o;
  endfunction

  function automatic obs_t observe_16();
    obs_t o;
    o.busy = busy16; o.done = done16; o.valid = sif16.valid;
    o.en_a = rd_en_a16; o.en_b = rd_en_b16; o.st = int'(st_16);
    o.addr_a = int'(rd_addr_a16); o.addr_b = int'(rd_addr_b16);
    o.idx1 = int'(sif16.index_col_1); o.idx2 = int'(sif16.index_col_2);
    o.c1r = sif16.col1_r; o.c1i = sif16.col1_i; o.c2r = sif16.col2_r; o.c2i = sif16.col2_i;
    return o;
  endfunction

  task automatic compare_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".busy"},   128'(a.busy),   128'(e.busy));
    chk({tag, ".done"},   128'(a.done),   128'(e.done));
    chk({tag, ".valid"},  128'(a.valid),  128'(e.valid));
    chk({tag, ".rd_en_a"}, 128'(a.en_a),  128'(e.en_a));
    chk({tag, ".rd_en_b"}, 128'(a.en_b),  128'(e.en_b));
    chk({tag, ".state"},  128'(a.st),     128'(e.st));
    chk({tag, ".rd_addr_a"}, 128'(a.addr_a), 128'(e.addr_a));
    chk({tag, ".rd_addr_b"}, 128'(a.addr_b), 128'(e.addr_b));
    chk({tag, ".index_col_1"}, 128'(a.idx1), 128'(e.idx1));
    chk({tag, ".index_col_2"}, 128'(a.idx2), 128'(e.idx2));
    chk({tag, ".col1_r"}, a.c1r, e.c1r);
    chk({tag, ".col1_i"}, a.c1i, e.c1i);
    chk({tag, ".col2_r"}, a.c2r, e.c2r);
    chk({tag, ".col2_i"}, a.c2i, e.c2i);
  endtask

  // Model bookkeeping: edge count and the accepting edge of each DUT's frame.
  longint cyc = 0;
  longint fs_big = 0, fs16 = 0;
  bit     fv_big = 1'b0, fv16 = 1'b0;
  bit     cmp_on = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      fv_big = 1'b0;
      fv16   = 1'b0;
    end else begin
      if (start && (!fv_big || cyc >= fs_big + ROWS / 2 + 4)) begin
        fs_big = cyc;
        fv_big = 1'b1;
      end
      if (start16 && (!fv16 || cyc >= fs16 + ROWS2 / 2 + 4)) begin
        fs16 = cyc;
        fv16 = 1'b1;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      if (!rst_n) begin
        fv_big = 1'b0;
        fv16   = 1'b0;
      end
      compare_obs("big", observe_big(), model(ROWS,  fv_big, cyc - fs_big));
      compare_obs("r16", observe_16(),  model(ROWS2, fv16,   cyc - fs16));
    end
  end

  // ---------------- driver tasks ----------------
  // One start pulse on the 2048-row DUT, then literal checks of the frame.
  // With poke set, start is pulsed again mid-frame and must be ignored.
  task automatic frame_big_literal(input string tag, input bit poke);
    int beat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_rise"}, 128'(busy), 128'(1));
    @(negedge clk);
    chk({tag, ".lat_e1"}, 128'(sif.valid), 128'(0));
    @(negedge clk);
    chk({tag, ".lat_e2"}, 128'(sif.valid), 128'(1));
    beat = 0;
    while (sif.valid === 1'b1 && beat < 1100) begin
      case (beat)
        0: begin
          chk({tag, ".b0.idx1"}, 128'(sif.index_col_1), 128'(0));
          chk({tag, ".b0.c1r2"}, 128'(sif.col1_r[2]), 128'(2));
          chk({tag, ".b0.col2r"}, 128'(sif.col2_r), 128'(0));
          chk({tag, ".b0.col2i"}, 128'(sif.col2_i), 128'(0));
          chk({tag, ".b0.idx2"}, 128'(sif.index_col_2), 128'(0));
        end
        1: begin
          chk({tag, ".b1.idx1"}, 128'(sif.index_col_1), 128'(1));
          chk({tag, ".b1.c1r0"}, 128'(sif.col1_r[0]), 128'(4));
        end
        2: begin
          chk({tag, ".b2.idx1"}, 128'(sif.index_col_1), 128'(2));
          chk({tag, ".b2.c1r0"}, 128'(sif.col1_r[0]), 128'(8));
          chk({tag, ".b2.idx2"}, 128'(sif.index_col_2), 128'(3));
          chk({tag, ".b2.c2r0"}, 128'(sif.col2_r[0]), 128'(12));
          chk({tag, ".b2.c2i0"}, 128'(sif.col2_i[0]), 128'(32'hFFFF_FFF3));
        end
        1024: begin
          chk({tag, ".last.idx1"}, 128'(sif.index_col_1), 128'(2046));
          chk({tag, ".last.idx2"}, 128'(sif.index_col_2), 128'(2047));
          chk({tag, ".last.c2r3"}, 128'(sif.col2_r[3]), 128'(8191));
        end
        default: ;
      endcase
      start = (poke && beat == 300) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (sif.valid === 1'b1) beat++;
    end
    start = 1'b0;
    chk({tag, ".beats"}, 128'(beat + 1), 128'(1025));
    chk({tag, ".done_pulse"}, 128'(done), 128'(1));
    chk({tag, ".busy_fall"}, 128'(busy), 128'(0));
    @(negedge clk);
    chk({tag, ".done_single"}, 128'(done), 128'(0));
    chk({tag, ".no_refire"}, 128'(busy), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  int        nv, nd, beats16;
  bit        found;
  logic [AW2-1:0] exp1_q[$], exp2_q[$], got1_q[$], got2_q[$];
  int        e1[9] = '{0, 1, 2, 4, 6, 8, 10, 12, 14};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start16 = 1'b0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (20) @(negedge clk);
    chk("s1.busy",  128'(busy),      128'(0));
    chk("s1.valid", 128'(sif.valid), 128'(0));
    chk("s1.rd_en_a", 128'(rd_en_a), 128'(0));
    chk("s1.col1_r", sif.col1_r,     128'(0));

    // 2: single frame, with a start pulse during busy
    frame_big_literal("s2", 1'b1);
    repeat (3) @(negedge clk);

    // 3: start held high -> two back-to-back frames (period 1028 edges)
    nv = 0;
    nd = 0;
    start = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      if (i == 2000) start = 1'b0;
      @(negedge clk);
      if (sif.valid === 1'b1) nv++;
      if (done === 1'b1) nd++;
    end
    chk("s3.beats", 128'(nv), 128'(2050));
    chk("s3.dones", 128'(nd), 128'(2));
    chk("s3.idle",  128'(busy), 128'(0));

    // 4: asynchronous reset at beat 500, then a clean restart
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (sif.valid === 1'b1 && sif.index_col_1 == AW'(998)) found = 1'b1;
    end
    chk("s4.reach_b500", 128'(found), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("s4.rst.valid", 128'(sif.valid), 128'(0));
    chk("s4.rst.busy",  128'(busy),      128'(0));
    chk("s4.rst.idx1",  128'(sif.index_col_1), 128'(0));
    chk("s4.rst.col1r", sif.col1_r,      128'(0));
    chk("s4.rst.rd_en_a", 128'(rd_en_a), 128'(0));
    chk("s4.rst.state", 128'(st_big),    128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s4.no_done", 128'(done), 128'(0));
    frame_big_literal("s4r", 1'b0);

    // 5/6: 16-row frame; port B returns garbage whenever it is not read
    foreach (e1[i]) exp1_q.push_back(AW2'(e1[i]));
    for (int i = 3; i <= 15; i += 2) exp2_q.push_back(AW2'(i));
    beats16 = 0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin
        chk("s6.k0.rd_en_a", 128'(rd_en_a16), 128'(1));
        chk("s6.k0.rd_en_b", 128'(rd_en_b16), 128'(0));
      end
      if (i == 1) chk("s6.k1.rd_en_b", 128'(rd_en_b16), 128'(0));
      if (i == 2) begin
        chk("s6.k2.rd_en_b",   128'(rd_en_b16),   128'(1));
        chk("s6.k2.rd_addr_b", 128'(rd_addr_b16), 128'(3));
      end
      if (sif16.valid === 1'b1) begin
        if (beats16 < 2) begin
          chk("s6.col2r_zero", sif16.col2_r, 128'(0));
          chk("s6.col2i_zero", sif16.col2_i, 128'(0));
        end
        got1_q.push_back(sif16.index_col_1);
        if (beats16 >= 2) got2_q.push_back(sif16.index_col_2);
        beats16++;
      end
      @(negedge clk);
    end
    chk("s5.beats", 128'(beats16), 128'(9));
    chk("s5.n_col2", 128'(got2_q.size()), 128'(exp2_q.size()));
    foreach (exp1_q[i]) begin
      if (i < got1_q.size()) chk("s5.idx1", 128'(got1_q[i]), 128'(exp1_q[i]));
      else chk("s5.idx1_missing", 128'(0), 128'(exp1_q[i]) + 128'(1));
    end
    foreach (exp2_q[i]) begin
      if (i < got2_q.size()) chk("s5.idx2", 128'(got2_q[i]), 128'(exp2_q[i]));
    end

    repeat (5) @(negedge clk);
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound.
  initial begin
    #300000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
